// File: rtl/cim_pkg.sv
// Shared definitions for the CIM partial-sum accumulator: mode codes, width
// defaults, FSM states and small mode-decoding helpers.
package cim_pkg;

  localparam int PSUM_W_DEF = 10;
  localparam int ACC_W_DEF  = 20;

  localparam logic [2:0] MODE_1B = 3'b000;
  localparam logic [2:0] MODE_4B = 3'b001;
  localparam logic [2:0] MODE_8B = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  function automatic logic mode_rsvd(input logic [2:0] m);
    return !((m == MODE_1B) || (m == MODE_4B) || (m == MODE_8B));
  endfunction

  // Reserved codes fall back to the single-beat 1-bit job.
  function automatic logic [3:0] beats_of(input logic [2:0] m);
    case (m)
      MODE_4B: return 4'd4;
      MODE_8B: return 4'd8;
      default: return 4'd1;
    endcase
  endfunction

  function automatic logic mode_signed(input logic [2:0] m);
    return (m == MODE_4B) || (m == MODE_8B);
  endfunction

endpackage

// File: rtl/cim_psum_accum_if.sv
// Bit-plane input / accumulated-result output bundle of cim_psum_accum.
interface cim_psum_accum_if
  import cim_pkg::*;
#(
  parameter int COLUMN_NUM = 512,
  parameter int PSUM_W     = PSUM_W_DEF,
  parameter int ACC_W      = ACC_W_DEF
);

  logic [2:0]                   mode;
  logic                         in_valid;
  logic                         in_ready;
  logic [COLUMN_NUM*PSUM_W-1:0] P;
  logic                         out_valid;
  logic                         out_ready;
  logic [COLUMN_NUM*ACC_W-1:0]  acc_out;
  logic                         mode_err;

  modport master (
    output mode, in_valid, P, out_ready,
    input  in_ready, out_valid, acc_out, mode_err
  );

  modport slave (
    input  mode, in_valid, P, out_ready,
    output in_ready, out_valid, acc_out, mode_err
  );

endinterface

// File: rtl/cim_psum_acc_lane.sv
// One shift-add lane: folds MSB-first bit-plane partial sums into a signed
// accumulator and captures the finished value into the output register.
// Optional ReLU on the output selected by CIM_PSUM_RELU_EN.
module cim_psum_acc_lane
  import cim_pkg::*;
#(
  parameter int PSUM_W = PSUM_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    beat_en,
  input  logic                    first,
  input  logic                    neg,
  input  logic                    cap,
  input  logic [PSUM_W-1:0]       p,
  output logic signed [ACC_W-1:0] res
);

  logic signed [ACC_W-1:0] p_ext;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [ACC_W-1:0] acc_p0;
  logic signed [ACC_W-1:0] res_p1;

  // ReLU only shapes what is presented; the accumulator keeps the raw value.
  function automatic logic signed [ACC_W-1:0] shape_out(input logic signed [ACC_W-1:0] a);
`ifdef CIM_PSUM_RELU_EN
    return (a < 0) ? '0 : a;
`else
    return a;
`endif
  endfunction

  assign p_ext = $signed({{(ACC_W-PSUM_W){1'b0}}, p});

  always_comb begin
    acc_nxt = acc_p0;
    if (first) acc_nxt = neg ? -p_ext : p_ext;
    else       acc_nxt = (acc_p0 <<< 1) + p_ext;
  end

  // p0: accumulator, p1: captured result
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p0 <= '0;
      res_p1 <= '0;
    end else begin
      if (beat_en) acc_p0 <= acc_nxt;
      if (cap)     res_p1 <= shape_out(acc_nxt);
    end
  end

  assign res = res_p1;

endmodule

// File: rtl/cim_psum_accum.sv
// CIM partial-sum accumulator top: shared IDLE/ACCUM/HOLD control and beat
// counter driving COLUMN_NUM shift-add lanes. Optional macro: CIM_PSUM_RELU_EN.
module cim_psum_accum
  import cim_pkg::*;
#(
  parameter int COLUMN_NUM = 512,
  parameter int PSUM_W     = PSUM_W_DEF,
  parameter int ACC_W      = ACC_W_DEF
) (
  input logic             clk,
  input logic             rst,
  cim_psum_accum_if.slave bus
);

  state_e     state, state_nxt;
  logic [2:0] mode_r;
  logic [3:0] cnt;
  logic [3:0] cnt_inc;
  logic [3:0] n_in;
  logic [3:0] n_r;
  logic       vld_p1;
  logic       beat_en, first, neg, cap, hs;
  logic       in_ready_c, mode_err_c;
  logic [COLUMN_NUM*ACC_W-1:0] acc_flat;

  assign n_in    = beats_of(bus.mode);
  assign n_r     = beats_of(mode_r);
  assign cnt_inc = cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready_c = 1'b1;
    beat_en    = 1'b0;
    first      = 1'b0;
    neg        = 1'b0;
    cap        = 1'b0;
    hs         = 1'b0;
    mode_err_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          beat_en    = 1'b1;
          first      = 1'b1;
          neg        = mode_signed(bus.mode);
          mode_err_c = mode_rsvd(bus.mode);
          if (n_in == 4'd1) begin
            cap       = 1'b1;
            state_nxt = ST_HOLD;
          end else begin
            state_nxt = ST_ACCUM;
          end
        end
      end
      ST_ACCUM: begin
        if (bus.in_valid) begin
          beat_en = 1'b1;
          if (cnt_inc == n_r) begin
            cap       = 1'b1;
            state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        in_ready_c = 1'b0;
        if (bus.out_ready) begin
          hs        = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Mode is only sampled on the first beat; later changes wait for IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r <= MODE_1B;
      cnt    <= 4'd0;
      vld_p1 <= 1'b0;
    end else begin
      if (first) begin
        mode_r <= mode_rsvd(bus.mode) ? MODE_1B : bus.mode;
        cnt    <= 4'd1;
      end else if (beat_en) begin
        cnt <= cnt_inc;
      end else if (hs) begin
        cnt <= 4'd0;
      end
      if (cap)     vld_p1 <= 1'b1;
      else if (hs) vld_p1 <= 1'b0;
    end
  end

  for (genvar j = 0; j < COLUMN_NUM; j++) begin : g_lane
    cim_psum_acc_lane #(
      .PSUM_W (PSUM_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .beat_en (beat_en),
      .first   (first),
      .neg     (neg),
      .cap     (cap),
      .p       (bus.P[j*PSUM_W +: PSUM_W]),
      .res     (acc_flat[j*ACC_W +: ACC_W])
    );
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = vld_p1;
  assign bus.mode_err  = mode_err_c & ~rst;
  assign bus.acc_out   = acc_flat;

endmodule

// File: tb/tb_cim_psum_accum.sv
// Directed-vector bench for cim_psum_accum; expected values are hand-computed
// shift-add results (with ReLU applied when CIM_PSUM_RELU_EN is defined).
module tb_cim_psum_accum;
  import cim_pkg::*;

  localparam int CN = 8;
  localparam int PW = 10;
  localparam int AW = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cim_psum_accum_if #(.COLUMN_NUM(CN), .PSUM_W(PW), .ACC_W(AW)) bus ();

  cim_psum_accum #(.COLUMN_NUM(CN), .PSUM_W(PW), .ACC_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int post(input int v);
`ifdef CIM_PSUM_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic int lane(input int j);
    logic signed [AW-1:0] t;
    t = bus.acc_out[j*AW +: AW];
    return int'(t);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_p(input int j, input int v);
    bus.P[j*PW +: PW] = v[PW-1:0];
  endtask

  task automatic set_p_all(input int v);
    for (int j = 0; j < CN; j++) set_p(j, v);
  endtask

  task automatic beat(input logic [2:0] m);
    bus.mode     = m;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_ov_drop"}, int'(bus.out_valid), 0);
    check({tag, "_ir_back"}, int'(bus.in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0[4] = '{1, 0, 0, 1};
    int v1[4] = '{0, 1, 1, 1};
    int v2[4] = '{1, 1, 1, 1};
    int hold_v;

    bus.mode      = MODE_1B;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.P         = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_mode_err", int'(bus.mode_err), 0);
    check("rst_lane0", lane(0), 0);

    // 1-bit, lane0=300, lane1=max popcount
    set_p_all(0);
    set_p(0, 300);
    set_p(1, 1023);
    bus.mode     = MODE_1B;
    bus.in_valid = 1'b1;
    #1;
    check("b1_mode_err", int'(bus.mode_err), 0);
    tick();
    bus.in_valid = 1'b0;
    check("b1_out_valid", int'(bus.out_valid), 1);
    check("b1_lane0", lane(0), 300);
    check("b1_lane1", lane(1), 1023);
    check("b1_in_ready", int'(bus.in_ready), 0);
    handshake("b1");

    // 4-bit, three distinct lane patterns
    set_p_all(0);
    for (int b = 0; b < 4; b++) begin
      set_p(0, v0[b]);
      set_p(1, v1[b]);
      set_p(2, v2[b]);
      if (b == 3) check("b4_ov_before_last", int'(bus.out_valid), 0);
      beat(MODE_4B);
    end
    check("b4_out_valid", int'(bus.out_valid), 1);
    check("b4_lane0", lane(0), post(-7));
    check("b4_lane1", lane(1), post(7));
    check("b4_lane2", lane(2), post(-1));
    check("b4_lane3", lane(3), 0);
    handshake("b4");

    // 8-bit, all lanes 5, two idle cycles after beat 3, mode changes mid-job
    set_p_all(5);
    for (int b = 0; b < 8; b++) begin
      check("b8_ov_early", int'(bus.out_valid), 0);
      beat((b == 0) ? MODE_8B : MODE_1B);
      if (b == 2) begin
        tick();
        check("b8_gap_ov", int'(bus.out_valid), 0);
        check("b8_gap_ir", int'(bus.in_ready), 1);
        tick();
      end
    end
    check("b8_out_valid", int'(bus.out_valid), 1);
    for (int j = 0; j < CN; j++) check($sformatf("b8_lane%0d", j), lane(j), post(-5));

    // Hold with out_ready low; extra in_valid must not be taken
    hold_v = lane(0);
    set_p_all(100);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("hold_in_ready", int'(bus.in_ready), 0);
      tick();
      check("hold_out_valid", int'(bus.out_valid), 1);
      check("hold_lane0", lane(0), hold_v);
    end
    bus.in_valid = 1'b0;
    handshake("hold");

    // Reset mid-job, then a fresh 1-bit job
    set_p_all(0);
    set_p(0, 3);
    beat(MODE_4B);
    beat(MODE_4B);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_ov", int'(bus.out_valid), 0);
    check("mid_rst_ir", int'(bus.in_ready), 1);
    check("mid_rst_lane0", lane(0), 0);
    set_p_all(0);
    set_p(0, 7);
    beat(MODE_1B);
    check("post_rst_ov", int'(bus.out_valid), 1);
    check("post_rst_lane0", lane(0), 7);
    check("post_rst_lane1", lane(1), 0);
    handshake("post_rst");

    // Reserved mode
    set_p_all(0);
    set_p(0, 9);
    bus.mode     = 3'b111;
    bus.in_valid = 1'b1;
    #1;
    check("rsvd_mode_err_on", int'(bus.mode_err), 1);
    tick();
    bus.in_valid = 1'b0;
    check("rsvd_mode_err_off", int'(bus.mode_err), 0);
    check("rsvd_out_valid", int'(bus.out_valid), 1);
    check("rsvd_lane0", lane(0), 9);
    handshake("rsvd");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
